// File: rtl/perceptron_layer_seq.sv
// Sequential binary-input perceptron layer: one input bit per clock, all neurons accumulate in parallel.
// Optional macro SIGNED_WEIGHT_EN switches weights/thresholds to two's complement.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a vector; weight/threshold writes accepted here
// S_ACCUM | one input bit per clock added into every accumulator
// S_CMP   | final sums settled; compare against thresholds
// S_DONE  | out_bits/out_valid held until out_ready
module perceptron_layer_seq #(
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_IN-1:0]                       in_vec,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_OUT-1:0]                      out_bits,
    input  logic                                  wr_en,
    input  logic [$clog2(N_OUT*(N_IN+1))-1:0]     wr_addr,
    input  logic [W_WIDTH-1:0]                    wr_data,
    output logic                                  wr_err
);

    localparam int N_ADDR = N_OUT * (N_IN + 1);
    localparam int ADDR_W = $clog2(N_ADDR);
    localparam int CNT_W  = $clog2(N_IN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_IN - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(N_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CMP, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [W_WIDTH-1:0]     w_mem   [N_OUT][N_IN];
    logic [W_WIDTH-1:0]     thr_mem [N_OUT];
    logic [ACC_WIDTH-1:0]   acc     [N_OUT];
    logic [N_IN-1:0]        in_vec_q;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;
    logic                   wr_ok;

    function automatic logic [ACC_WIDTH-1:0] ext_w(input logic [W_WIDTH-1:0] v);
`ifdef SIGNED_WEIGHT_EN
        return {{(ACC_WIDTH-W_WIDTH){v[W_WIDTH-1]}}, v};
`else
        return {{(ACC_WIDTH-W_WIDTH){1'b0}}, v};
`endif
    endfunction

    function automatic logic fires(input logic [ACC_WIDTH-1:0] a, input logic [ACC_WIDTH-1:0] t);
`ifdef SIGNED_WEIGHT_EN
        return $signed(a) > $signed(t);
`else
        return a > t;
`endif
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign wr_ok     = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < ADDR_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)        state_nxt = S_ACCUM;
            S_ACCUM: if (cnt == CNT_LAST) state_nxt = S_CMP;
            S_CMP:                        state_nxt = S_DONE;
            S_DONE:  if (out_ready)       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Register file: flat address n*(N_IN+1)+i, slot N_IN of each neuron is its threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_OUT; n++) begin
                for (int i = 0; i < N_IN; i++) w_mem[n][i] <= '0;
                thr_mem[n] <= '0;
            end
        end else if (wr_ok) begin
            for (int n = 0; n < N_OUT; n++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (wr_addr == ADDR_W'(n * (N_IN + 1) + i)) w_mem[n][i] <= wr_data;
                end
                if (wr_addr == ADDR_W'(n * (N_IN + 1) + N_IN)) thr_mem[n] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else        wr_err <= wr_en && !wr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vec_q <= '0;
            cnt      <= '0;
            out_bits <= '0;
            for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        in_vec_q <= in_vec;
                        cnt      <= '0;
                        for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
                    end
                end
                S_ACCUM: begin
                    for (int n = 0; n < N_OUT; n++) begin
                        acc[n] <= acc[n] + (in_vec_q[cnt] ? ext_w(w_mem[n][cnt]) : '0);
                    end
                    cnt <= cnt + 1'b1;
                end
                S_CMP: begin
                    for (int n = 0; n < N_OUT; n++) out_bits[n] <= fires(acc[n], ext_w(thr_mem[n]));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Scoreboard bench for perceptron_layer_seq: driver pushes expected out_bits, monitor pops on output.
module tb_perceptron_layer_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_vec, out_bits;
    logic       wr_en, wr_err;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    typedef struct {
        logic [7:0] bits;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   prev_valid = 1'b0;
    logic [7:0] wts [8];

    perceptron_layer_seq #(.N_IN(8), .N_OUT(8), .W_WIDTH(8), .ACC_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge, away from all driver activity.
    initial forever begin
        @(negedge clk);
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                if (!prev_valid) check("latency", cyc - sb[0].acc_cyc, 32'd9);
                check("out_bits", {24'b0, out_bits}, {24'b0, sb[0].bits});
                if (!out_ready) check("in_ready_busy", {31'b0, in_ready}, 32'd0);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic wr(input logic [6:0] addr, input logic [7:0] data, input logic exp_err);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        #1 check("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
        @(negedge clk);
        #1 check("wr_err_pulse", {31'b0, wr_err}, 32'd0);
    endtask

    task automatic send(input logic [7:0] vec, input logic [7:0] exp, input bit push);
        bit ok = 1'b0;
        @(negedge clk);
        in_vec = vec; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept", {31'b0, ok}, 32'd1);
        if (ok && push) sb.push_back('{bits: exp, acc_cyc: cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && in_ready && !out_valid) break;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        check("wait_valid", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        in_valid = 0; in_vec = 0; out_ready = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        wts = '{8'd2, 8'd4, 8'd2, 8'd1, 8'd5, 8'd2, 8'd2, 8'd2};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_bits", {24'b0, out_bits}, 32'd0);
        check("rst_wr_err", {31'b0, wr_err}, 32'd0);
        rst_n = 1'b1;
        send(8'hFF, 8'h00, 1'b1);
        wait_idle();

        // Load n0..n2 with shared weights, n3 with one-hot powers of two
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) wr(7'(n * 9 + i), wts[i], 1'b0);
        end
        wr(7'd8, 8'd0, 1'b0);
        wr(7'd17, 8'd19, 1'b0);
        wr(7'd26, 8'd20, 1'b0);
        for (int i = 0; i < 8; i++) wr(7'(27 + i), 8'(1 << i), 1'b0);
        wr(7'd35, 8'd15, 1'b0);

        send(8'hFF, 8'h0B, 1'b1);
        send(8'h00, 8'h00, 1'b1);
        send(8'h0F, 8'h01, 1'b1);
        send(8'h12, 8'h09, 1'b1);
        send(8'h10, 8'h09, 1'b1);
        wait_idle();

        // Backpressure: second vector must wait for the handshake
        out_ready = 1'b0;
        send(8'hFF, 8'h0B, 1'b1);
        fork
            send(8'h0F, 8'h01, 1'b1);
            begin
                wait_valid();
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_idle();

        // Rejected writes: busy, then out of range
        send(8'hFF, 8'h0B, 1'b1);
        wr(7'd0, 8'd99, 1'b1);
        wait_idle();
        wr(7'd72, 8'd5, 1'b1);
        send(8'hFF, 8'h0B, 1'b1);
        send(8'h0F, 8'h01, 1'b1);
        wait_idle();

        // Reset mid-ACCUM aborts and clears weights
        send(8'hFF, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_bits", {24'b0, out_bits}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send(8'hFF, 8'h00, 1'b1);
        wait_idle();

        // All weights 0xFF, thresholds 0xF8
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 8; i++) wr(7'(n * 9 + i), 8'hFF, 1'b0);
            wr(7'(n * 9 + 8), 8'hF8, 1'b0);
        end
`ifdef SIGNED_WEIGHT_EN
        send(8'hFF, 8'h00, 1'b1);
        send(8'h7F, 8'hFF, 1'b1);
        send(8'h00, 8'hFF, 1'b1);
`else
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h7F, 8'hFF, 1'b1);
        send(8'h00, 8'h00, 1'b1);
`endif
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
